// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold/load/shift/rotate/ashr/clear, plus a multi-step shift engine.
// Optional: define SHIFT_REG_UNIV_PARITY_EN to add a registered even-parity output of q.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef SHIFT_REG_UNIV_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_ASHR  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  q_next;
    logic [AW-1:0]     count_reg;
    logic [2:0]        mode_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [2:0]        step_mode;
    logic [WIDTH-1:0]  up_q;
    logic [WIDTH-1:0]  dn_q;
    logic [WIDTH-1:0]  step_q;
    logic              accept;

    // Only the shift/rotate family may launch the multi-step engine.
    assign accept    = (state_reg == IDLE) && start && (mode >= M_SHL) && (mode <= M_ASHR);
    assign step_mode = (state_reg == RUN) ? mode_reg : mode;

    // up_q moves bits toward the MSB, dn_q toward the LSB; the end bit depends on the mode.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_nbr
            if (gi == 0) begin : g_lsb
                assign up_q[gi] = (step_mode == M_ROTL) ? q_reg[WIDTH-1] : sin_l;
            end else begin : g_up
                assign up_q[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign dn_q[gi] = (step_mode == M_ROTR) ? q_reg[0]
                                : (step_mode == M_ASHR) ? q_reg[WIDTH-1]
                                : sin_r;
            end else begin : g_dn
                assign dn_q[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        step_q = q_reg;
        case (step_mode)
            M_HOLD:                 step_q = q_reg;
            M_LOAD:                 step_q = d;
            M_SHL, M_ROTL:          step_q = up_q;
            M_SHR, M_ROTR, M_ASHR:  step_q = dn_q;
            M_CLEAR:                step_q = '0;
            default:                step_q = q_reg;
        endcase
    end

    always_comb begin
        q_next = q_reg;
        if (state_reg == RUN) begin
            q_next = step_q;
        end else if (accept) begin
            if (amt != '0) begin
                q_next = step_q;
            end
        end else if (en) begin
            q_next = step_q;
        end
    end

`ifdef SHIFT_REG_UNIV_PARITY_EN
    logic parity_reg;
    assign parity = parity_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            count_reg <= '0;
            mode_reg  <= M_HOLD;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SHIFT_REG_UNIV_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            q_reg    <= q_next;
            done_reg <= 1'b0;
`ifdef SHIFT_REG_UNIV_PARITY_EN
            parity_reg <= ^q_next;
`endif
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mode_reg <= mode;
                        // The accepting edge already performs the first step.
                        if (amt > AW'(1)) begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                            count_reg <= amt - AW'(1);
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    count_reg <= count_reg - AW'(1);
                    if (count_reg == AW'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = q_reg;
    assign sout_l = q_reg[WIDTH-1];
    assign sout_r = q_reg[0];
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, AW=4): vector table for single steps plus multi-cycle sequences.
module tb_shift_reg_univ;

    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
`ifdef SHIFT_REG_UNIV_PARITY_EN
    logic             parity;
`endif

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .amt    (amt),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
`ifdef SHIFT_REG_UNIV_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; start = 1'b0; mode = 3'b000; d = '0;
        sin_l = 1'b0; sin_r = 1'b0; amt = '0;
    endtask

    task automatic load(input logic [7:0] val);
        idle_inputs();
        en = 1'b1; mode = 3'b001; d = val;
        tick();
        idle_inputs();
        chk("load_setup", q, val);
    endtask

    typedef struct {
        logic       en;
        logic       start;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [3:0] amt;
        logic [7:0] q;
        logic       busy;
        logic       done;
        string      name;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] eq;
        int edges;
        logic saw_done;

        vecs[0]  = '{1'b1, 1'b0, 3'b001, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, "load"};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 8'hA5, 1'b1, 1'b0, 4'd0, 8'h4B, 1'b0, 1'b0, "shl"};
        vecs[2]  = '{1'b1, 1'b0, 3'b011, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0, "shr"};
        vecs[3]  = '{1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0, "en0_hold"};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 8'h96, 1'b0, 1'b0, 4'd0, 8'h96, 1'b0, 1'b0, "load96"};
        vecs[5]  = '{1'b1, 1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0, 8'hCB, 1'b0, 1'b0, "ashr"};
        vecs[6]  = '{1'b1, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 4'd0, 8'h97, 1'b0, 1'b0, "rotl"};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 4'd0, 8'hCB, 1'b0, 1'b0, "rotr"};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 8'hFF, 1'b1, 1'b1, 4'd0, 8'hCB, 1'b0, 1'b0, "hold"};
        vecs[9]  = '{1'b1, 1'b0, 3'b111, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, "clear"};
        vecs[10] = '{1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 4'd5, 8'h3C, 1'b0, 1'b0, "start_load"};
        vecs[11] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 4'd3, 8'h3C, 1'b0, 1'b0, "start_clear_en0"};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 8'h00, 1'b0, 1'b1, 4'd0, 8'h9E, 1'b0, 1'b0, "shr_sin1"};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_q", q, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en; start = vecs[i].start; mode = vecs[i].mode; d = vecs[i].d;
            sin_l = vecs[i].sl; sin_r = vecs[i].sr; amt = vecs[i].amt;
            tick();
            eq = vecs[i].q;
            chk({vecs[i].name, "_q"}, q, eq);
            chk({vecs[i].name, "_busy"}, busy, vecs[i].busy);
            chk({vecs[i].name, "_done"}, done, vecs[i].done);
            chk({vecs[i].name, "_sout_l"}, sout_l, eq[7]);
            chk({vecs[i].name, "_sout_r"}, sout_r, eq[0]);
            $display("vec %0d %s: q=0x%02h busy=%0b done=%0b", i, vecs[i].name, q, busy, done);
        end

        // Multi-step rotl with en/start/mode/d toggled while running.
        load(8'h81);
        start = 1'b1; mode = 3'b100; amt = 4'd3;
        tick();
        chk("rotl3_e1_q", q, 8'h03);
        chk("rotl3_e1_busy", busy, 1'b1);
        chk("rotl3_e1_done", done, 1'b0);
        start = 1'b1; mode = 3'b111; en = 1'b1; d = 8'hFF; amt = 4'd0;
        tick();
        chk("rotl3_e2_q", q, 8'h06);
        chk("rotl3_e2_busy", busy, 1'b1);
        start = 1'b0; mode = 3'b001; en = 1'b1; d = 8'hFF;
        tick();
        chk("rotl3_e3_q", q, 8'h0C);
        chk("rotl3_e3_busy", busy, 1'b0);
        chk("rotl3_e3_done", done, 1'b1);
        chk("rotl3_sout_l", sout_l, 1'b0);
        chk("rotl3_sout_r", sout_r, 1'b0);
        idle_inputs();
        tick();
        chk("rotl3_after_done", done, 1'b0);
        chk("rotl3_after_q", q, 8'h0C);
        $display("seq rotl3: q=0x%02h", q);

        // amt=0: no step, done next cycle, never busy.
        start = 1'b1; mode = 3'b010; amt = 4'd0; sin_l = 1'b1;
        tick();
        chk("amt0_q", q, 8'h0C);
        chk("amt0_done", done, 1'b1);
        chk("amt0_busy", busy, 1'b0);
        $display("seq amt0: q=0x%02h done=%0b", q, done);

        // amt=1 shr, then a back-to-back start in the done cycle.
        start = 1'b1; mode = 3'b011; amt = 4'd1; sin_r = 1'b1; sin_l = 1'b0;
        tick();
        chk("amt1_q", q, 8'h86);
        chk("amt1_done", done, 1'b1);
        chk("amt1_busy", busy, 1'b0);
        start = 1'b1; mode = 3'b100; amt = 4'd2; sin_r = 1'b0;
        tick();
        chk("b2b_e1_q", q, 8'h0D);
        chk("b2b_e1_busy", busy, 1'b1);
        chk("b2b_e1_done", done, 1'b0);
        idle_inputs();
        tick();
        chk("b2b_e2_q", q, 8'h1A);
        chk("b2b_e2_done", done, 1'b1);
        chk("b2b_e2_busy", busy, 1'b0);
        tick();
        chk("b2b_after_done", done, 1'b0);
        $display("seq b2b: q=0x%02h", q);

        // amt=15 rotr on 0x01 wraps modulo 8 -> 0x02.
        load(8'h01);
        start = 1'b1; mode = 3'b101; amt = 4'd15;
        tick();
        edges = 1;
        idle_inputs();
        chk("rotr15_busy", busy, 1'b1);
        for (int k = 0; k < 20 && !done; k++) begin
            if (busy && done) chk("busy_and_done", 1'b1, 1'b0);
            tick();
            edges++;
        end
        chk("rotr15_done", done, 1'b1);
        chk("rotr15_edges", edges, 15);
        chk("rotr15_q", q, 8'h02);
        chk("rotr15_busy_at_done", busy, 1'b0);
        $display("seq rotr15: q=0x%02h edges=%0d", q, edges);

        // ashr with amt > WIDTH saturates to all-sign.
        load(8'h80);
        start = 1'b1; mode = 3'b110; amt = 4'd10;
        tick();
        idle_inputs();
        for (int k = 0; k < 20 && !done; k++) tick();
        chk("ashr10_done", done, 1'b1);
        chk("ashr10_q", q, 8'hFF);
        $display("seq ashr10: q=0x%02h", q);

        // Reset during RUN abandons the operation with no done pulse.
        load(8'h0F);
        start = 1'b1; mode = 3'b100; amt = 4'd6;
        tick();
        chk("rst_run_e1_q", q, 8'h1E);
        idle_inputs();
        tick();
        chk("rst_run_e2_q", q, 8'h3C);
        chk("rst_run_e2_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_run_q", q, 8'h00);
        chk("rst_run_busy", busy, 1'b0);
        chk("rst_run_done", done, 1'b0);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            saw_done = saw_done | done;
        end
        chk("rst_run_no_done", saw_done, 1'b0);
        chk("rst_run_q_after", q, 8'h00);
        $display("seq reset_in_run: q=0x%02h saw_done=%0b", q, saw_done);

`ifdef SHIFT_REG_UNIV_PARITY_EN
        load(8'h07);
        chk("parity_07", parity, 1'b1);
        en = 1'b1; mode = 3'b010; sin_l = 1'b1;
        tick();
        idle_inputs();
        chk("parity_shl_q", q, 8'h0F);
        chk("parity_0F", parity, 1'b0);
        $display("seq parity: q=0x%02h parity=%0b", q, parity);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal register, successor to the single-bit D flip-flop with reset.
- WIDTH-bit register with per-cycle modes: hold, parallel load, shift, rotate, arithmetic shift and clear.
- Adds a multi-step shift engine: one start command performs N shift/rotate steps autonomously, with busy/done status.
- Used as a datapath building block for serialisers, barrel-free shifters and bit-serial arithmetic.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AW, 4, width of the step-count input amt; counts 0..2^AW-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- en  input  1  single-step enable for mode operation.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering bit 0 on shift-left.
- sin_r  input  1  serial input entering bit WIDTH-1 on shift-right.
- start  input  1  launch multi-step operation.
- amt  input  AW  step count for start.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- busy  output  1  multi-step operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset, sampled only on the rising clk edge.
- Reset values: q=0, busy=0, done=0, internal count=0, state=IDLE. Reset overrides everything, including mid-RUN; any operation in progress is abandoned with no done pulse.
- Mode encoding (one step):
  - 000 hold.
  - 001 load: q=d.
  - 010 shl: q={q[W-2:0],sin_l}.
  - 011 shr: q={sin_r,q[W-1:1]}.
  - 100 rotl.
  - 101 rotr.
  - 110 ashr: MSB replicated.
  - 111 clear: q=0.
- FSM states are IDLE and RUN.
- IDLE priority order is reset > start > en.
- Single-step: in IDLE with start=0 and en=1, apply mode at the edge; latency 1 cycle. With en=0, q holds.
- Start acceptance: start=1 in IDLE with mode in 010..110 is accepted. Mode is latched for the whole operation.
- Start with amt=0: q unchanged; done=1 for the next cycle; busy stays 0.
- Start with amt=1: one step at the accepting edge; done=1 for the next cycle; busy stays 0.
- Start with amt>=2: first step at the accepting edge; count loaded with amt-1; state goes to RUN, busy=1.
- In RUN: one step per edge and count decrements. At the edge where the count goes 1->0: state goes to IDLE, busy=0, done=1 for exactly one cycle.
  - done is first high in the cycle where q shows the final value.
  - Total: amt steps in amt edges.
- start with mode 000, 001 or 111: start is ignored; the cycle behaves as en-driven single step.
- In RUN, en, start, mode, d and amt are ignored. sin_l and sin_r are still sampled live each step.
- amt > WIDTH is legal:
  - shl/shr shift in serial bits every step.
  - rotate wraps modulo WIDTH.
  - ashr saturates to all-sign.
- done and busy are never high together. A new start is accepted in the same cycle done is high, since the state is IDLE.

Optional Feature:
- Macro: SHIFT_REG_UNIV_PARITY_EN.
- Defined: adds output port parity (1 bit), registered even parity (XOR of all bits) of q. It updates on the same edge as q, so parity always equals ^q. Reset value is 0.
- Undefined: port absent; no parity logic.

Test Plan:
All cases use WIDTH=8, AW=4.
- Reset during RUN: start rotl amt=6 on q=0x0F, assert reset 2 cycles later -> next edge q=0x00, busy=0, done never pulses.
- Single-step modes, en=1, d=0xA5:
  - load -> q=0xA5.
  - shl sin_l=1 -> 0x4B.
  - shr sin_r=0 -> 0x25.
  - ashr on 0x96 -> 0xCB.
  - clear -> 0x00.
  - en=0 holds value.
- Multi-step rotl: q=0x81, start mode=100 amt=3 -> busy high 2 cycles, done one cycle with q=0x0C; sout_l/sout_r track q.
- Boundary amt:
  - amt=0 -> q unchanged, done next cycle, busy never high.
  - amt=1 shr -> one step, done next cycle.
  - amt=15 rotr on 0x01 -> q=0x02 at done.
- Ignore rules:
  - start with mode=001 acts as load, no done.
  - en/start/mode toggled during RUN have no effect.
  - Back-to-back start in the done cycle is accepted.
- Parity (macro defined): load 0x07 -> parity=1; shl sin_l=1 -> q=0x0F, parity=0.
